instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline and the requesting side of the IMEM interface. Holds the PC,
//   drives the IMEM byte address and captures the returned word into the IF/ID pipeline register.
//   Applies stall from the hazard unit and branch/jump redirect plus flush from later stages.
//   IMEM read is combinational, so each fetch completes in the same cycle it is addressed.
// PARAMETERS
//   ADDR_W    7             IMEM byte-address width; imem_addr = pc[ADDR_W-1:0]
//   RESET_PC  32'h00000000  PC value loaded on reset
//   NOP       32'h00000000  word written to ifid_instr on reset and on flush (sll $0,$0,0)
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous, active-low reset
//   stall          in   1       hold PC and IF/ID (load-use hazard)
//   flush          in   1       squash the instruction being loaded into IF/ID
//   pc_src         in   2       00 sequential, 01 branch, 10 jump, 11 treated as 00
//   branch_target  in   32      branch destination byte address
//   jump_index     in   26      J-type instr_index field
//   imem_addr      out  ADDR_W  byte address to IMEM (combinational from pc)
//   imem_data      in   32      instruction word returned by IMEM
//   ifid_instr     out  32      IF/ID instruction register
//   ifid_pc4       out  32      IF/ID PC+4 register
//   ifid_valid     out  1       IF/ID holds a real (non-squashed) instruction
//   fetch_cnt      out  32      count of valid instructions loaded into IF/ID, saturating
// BEHAVIOUR
//   Reset (async on rst_n low, any time incl. mid-operation): pc=RESET_PC, ifid_instr=NOP,
//     ifid_pc4=0, ifid_valid=0, fetch_cnt=0. Outputs take reset values immediately, without a clock.
//   imem_addr = pc[ADDR_W-1:0]; pc[1:0] is always 0 (low 2 bits of targets are discarded).
//   pc4 = pc + 32'd4 (32-bit wrap). jump target = {pc4[31:28], jump_index, 2'b00}.
//   PC update each rising edge, priority order:
//     1. pc_src==01 -> pc <= {branch_target[31:2],2'b00}
//     2. pc_src==10 -> pc <= jump target
//     3. stall      -> pc holds
//     4. otherwise  -> pc <= pc4
//   Redirect wins over stall: a simultaneous stall and redirect always loads the target.
//   IF/ID update each rising edge, priority order:
//     1. flush -> ifid_instr<=NOP, ifid_pc4<=0, ifid_valid<=0
//     2. stall -> all IF/ID registers hold (valid included)
//     3. else  -> ifid_instr<=imem_data, ifid_pc4<=pc4, ifid_valid<=1
//   Latency: the word at address A appears on ifid_instr one edge after pc==A with no stall/flush.
//   fetch_cnt increments by 1 on every edge where case 3 loads IF/ID. It saturates at 32'hFFFFFFFF.
//   pc_src==11 is treated exactly as 00 and generates no error.
//   Address wrap: pc increments past 2^ADDR_W. imem_addr wraps to 0 via truncation, while
//     ifid_pc4 keeps the full 32-bit value.
//   The caller asserts flush together with any redirect. A redirect without flush is legal and
//     keeps the sequentially fetched instruction.
//   The block decodes nothing. It stores no state other than pc, the IF/ID registers and fetch_cnt.
// TESTING
//   1. Reset low for 2 cycles, then release. IMEM returns 0x20080020 at addr 0 and 0x20090037 at addr 4.
//      Required: imem_addr sequence 0,4,8. After edge 1: ifid_instr=0x20080020, ifid_pc4=4,
//      ifid_valid=1. After edge 2: ifid_pc4=8 and fetch_cnt=2.
//   2. With pc=0x0C, hold stall high for 2 edges. Required: pc stays 0x0C, IF/ID and fetch_cnt hold.
//      After stall is released, pc advances to 0x10.
//   3. With pc=0x24, set pc_src=01, branch_target=0x48, flush=1 for 1 edge. Required: pc=0x48,
//      ifid_instr=NOP, ifid_valid=0, fetch_cnt unchanged. The next edge loads the word at 0x48.
//   4. With pc=0x44, set pc_src=10, jump_index=0x00000E, flush=1. Required: pc=0x38,
//      and the next ifid_instr is the word at 0x38.
//   5. Assert stall=1 and pc_src=01 (target 0x20) together, with flush=0. Required: pc=0x20 and
//      IF/ID holds its previous contents.
//   6. Pull rst_n low mid-run between edges with pc=0x30 and ifid_valid=1. Required: all outputs
//      reset with no clock edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, addresses IMEM combinationally and
// loads the returned word into the IF/ID register under stall, flush and redirect control.
module instr_fetch #(
   parameter int          ADDR_W   = 7,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic [1:0]        i_pc_src,
   input  logic [31:0]       i_branch_target,
   input  logic [25:0]       i_jump_index,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [31:0]       i_imem_data,
   output logic [31:0]       o_ifid_instr,
   output logic [31:0]       o_ifid_pc4,
   output logic              o_ifid_valid,
   output logic [31:0]       o_fetch_cnt
);

   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc4;
   logic        r_ifid_valid;
   logic [31:0] r_fetch_cnt;

   logic [31:0] w_pc4;
   logic [31:0] w_jump_target;
   logic [31:0] w_pc_next;
   logic        w_load;

   assign w_pc4         = r_pc + 32'd4;
   assign w_jump_target = {w_pc4[31:28], i_jump_index, 2'b00};
   assign w_load        = (!i_flush) && (!i_stall);

   // Next-PC select: a redirect overrides stall; pc_src 11 behaves as sequential.
   always_comb begin
      w_pc_next = w_pc4;
      case (i_pc_src)
         2'b01: w_pc_next = {i_branch_target[31:2], 2'b00};
         2'b10: w_pc_next = w_jump_target;
         default: begin
            if (i_stall) begin
               w_pc_next = r_pc;
            end else begin
               w_pc_next = w_pc4;
            end
         end
      endcase
   end

   // Program counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   // IF/ID register: flush squashes, stall holds, otherwise capture the fetched word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ifid_instr <= NOP;
         r_ifid_pc4   <= 32'd0;
         r_ifid_valid <= 1'b0;
      end else if (i_flush) begin
         r_ifid_instr <= NOP;
         r_ifid_pc4   <= 32'd0;
         r_ifid_valid <= 1'b0;
      end else if (i_stall) begin
         r_ifid_instr <= r_ifid_instr;
         r_ifid_pc4   <= r_ifid_pc4;
         r_ifid_valid <= r_ifid_valid;
      end else begin
         r_ifid_instr <= i_imem_data;
         r_ifid_pc4   <= w_pc4;
         r_ifid_valid <= 1'b1;
      end
   end

   // Saturating count of real instructions loaded into IF/ID.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_cnt <= 32'd0;
      end else if (w_load && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
         r_fetch_cnt <= r_fetch_cnt;
      end
   end

   assign o_imem_addr  = r_pc[ADDR_W-1:0];
   assign o_ifid_instr = r_ifid_instr;
   assign o_ifid_pc4   = r_ifid_pc4;
   assign o_ifid_valid = r_ifid_valid;
   assign o_fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized control traffic
// compared against a cycle-level behavioural model of the IF stage.
module tb_instr_fetch;

   localparam int          ADDR_W = 7;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              stall;
   logic              flush;
   logic [1:0]        pc_src;
   logic [31:0]       branch_target;
   logic [25:0]       jump_index;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic [31:0]       ifid_instr;
   logic [31:0]       ifid_pc4;
   logic              ifid_valid;
   logic [31:0]       fetch_cnt;

   logic [31:0] mem [0:31];

   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic [31:0] m_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[ADDR_W-1:2]];

   instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_pc_src(pc_src),
      .i_branch_target(branch_target), .i_jump_index(jump_index), .o_imem_addr(imem_addr),
      .i_imem_data(imem_data), .o_ifid_instr(ifid_instr), .o_ifid_pc4(ifid_pc4),
      .o_ifid_valid(ifid_valid), .o_fetch_cnt(fetch_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, ".addr"},  {25'd0, imem_addr}, {25'd0, m_pc[ADDR_W-1:0]});
      check_val({tag, ".instr"}, ifid_instr, m_instr);
      check_val({tag, ".pc4"},   ifid_pc4, m_pc4);
      check_val({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
      check_val({tag, ".cnt"},   fetch_cnt, m_cnt);
   endtask

   task automatic model_reset();
      m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
   endtask

   // One clock edge: apply controls, advance the model by the IF-stage rules, then compare.
   task automatic cycle(input logic st, input logic fl, input logic [1:0] src,
                        input logic [31:0] bt, input logic [25:0] ji, input string tag);
      logic [31:0] seq;
      stall = st; flush = fl; pc_src = src; branch_target = bt; jump_index = ji;
      @(posedge clk);
      seq = m_pc + 32'd4;
      if (fl) begin
         m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
      end else if (!st) begin
         m_instr = mem[m_pc[ADDR_W-1:2]]; m_pc4 = seq; m_valid = 1'b1;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      if (src == 2'b01)      m_pc = bt & 32'hFFFF_FFFC;
      else if (src == 2'b10) m_pc = (seq & 32'hF000_0000) | ({6'd0, ji} << 2);
      else if (!st)          m_pc = seq;
      #1;
      check_all(tag);
   endtask

   task automatic seq_cycle(input string tag);
      cycle(1'b0, 1'b0, 2'b00, 32'd0, 26'd0, tag);
   endtask

   // Asynchronous reset pulse between clock edges, checked before any edge arrives.
   task automatic async_reset(input string tag);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] w38;
      logic [31:0] w48;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'h2008_0020;
      mem[1] = 32'h2009_0037;
      w38 = mem[14];
      w48 = mem[18];
      stall = 1'b0; flush = 1'b0; pc_src = 2'b00; branch_target = 32'd0; jump_index = 26'd0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential start-up
      seq_cycle("t1.e1");
      check_val("t1.instr0", ifid_instr, 32'h2008_0020);
      check_val("t1.pc4_0", ifid_pc4, 32'd4);
      seq_cycle("t1.e2");
      check_val("t1.pc4_1", ifid_pc4, 32'd8);
      check_val("t1.cnt", fetch_cnt, 32'd2);
      seq_cycle("t1.e3");

      // Stall holds PC and IF/ID
      cycle(1'b1, 1'b0, 2'b00, 32'd0, 26'd0, "t2.s1");
      cycle(1'b1, 1'b0, 2'b00, 32'd0, 26'd0, "t2.s2");
      check_val("t2.pc_hold", {25'd0, imem_addr}, 32'h0C);
      seq_cycle("t2.rel");
      check_val("t2.pc_adv", {25'd0, imem_addr}, 32'h10);

      // Branch with flush from 0x24
      repeat (5) seq_cycle("t3.seq");
      cycle(1'b0, 1'b1, 2'b01, 32'h48, 26'd0, "t3.br");
      check_val("t3.pc", {25'd0, imem_addr}, 32'h48);
      check_val("t3.valid", {31'd0, ifid_valid}, 32'd0);
      seq_cycle("t3.next");
      check_val("t3.word48", ifid_instr, w48);

      // Redirect without flush to 0x44, then jump with flush
      cycle(1'b0, 1'b0, 2'b01, 32'h47, 26'd0, "t4.br");
      cycle(1'b0, 1'b1, 2'b10, 32'd0, 26'h00000E, "t4.jmp");
      check_val("t4.pc", {25'd0, imem_addr}, 32'h38);
      seq_cycle("t4.next");
      check_val("t4.word38", ifid_instr, w38);

      // Stall together with branch: target wins, IF/ID holds
      cycle(1'b1, 1'b0, 2'b01, 32'h20, 26'd0, "t5");
      check_val("t5.pc", {25'd0, imem_addr}, 32'h20);

      // pc_src 11 acts as sequential; then mid-run async reset at pc 0x30
      cycle(1'b0, 1'b0, 2'b11, 32'h7C, 26'h3FFFFFF, "t6.src3");
      repeat (3) seq_cycle("t6.seq");
      check_val("t6.pc30", {25'd0, imem_addr}, 32'h30);
      async_reset("t6.rst");
      seq_cycle("t6.restart");

      // Address wrap: jump to 0x70 then run sequentially past 2^ADDR_W
      cycle(1'b0, 1'b1, 2'b10, 32'd0, 26'h1C, "wrap.jmp");
      repeat (8) seq_cycle("wrap.seq");
      check_val("wrap.pc4", ifid_pc4, 32'h90);

      // Randomized control traffic
      for (int i = 0; i < 3000; i++) begin
         logic [1:0]  src;
         logic        st;
         logic        fl;
         logic [31:0] r;
         r   = $urandom;
         st  = (r[3:0] < 4'd3);
         fl  = (r[7:4] < 4'd2);
         src = (r[11:8] < 4'd2) ? 2'b01 : (r[11:8] < 4'd3) ? 2'b10 :
               (r[11:8] < 4'd4) ? 2'b11 : 2'b00;
         if (src == 2'b01 || src == 2'b10) fl = r[12];
         cycle(st, fl, src, $urandom, 26'($urandom), "rand");
         if (r[31:22] == 10'd0) async_reset("rand.rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
